// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } fetch_state_e;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response bus between fetch and imem.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/redirect_sel.sv
// Redirect detection and target select from EX; jump outranks branch.
module redirect_sel
    import fetch_pkg::*;
(
    input  logic            pc_src,
    input  logic [1:0]      jump,
    input  logic [XLEN-1:0] branch_addr,
    input  logic [XLEN-1:0] jump_addr,
    output logic            redirect_c,
    output logic [XLEN-1:0] target_c
);

    always_comb begin
        redirect_c = 1'b0;
        target_c   = align_word(branch_addr);
        case (jump)
            JUMP_NONE: redirect_c = pc_src;
            JUMP_JAL: begin
                redirect_c = 1'b1;
                target_c   = align_word(jump_addr);
            end
            JUMP_JALR: begin
                redirect_c = 1'b1;
                target_c   = align_word(jump_addr);
            end
            // 2'b11 decodes as jalr
            default: begin
                redirect_c = 1'b1;
                target_c   = align_word(jump_addr);
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, single-outstanding imem request FSM,
// wrong-path kill tracking and the registered IF output buffer.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_src,
    input  logic [XLEN-1:0]  branch_addr,
    input  logic [1:0]       jump,
    input  logic [XLEN-1:0]  jump_addr,
    fetch_ctrl_if.master     imem,
    output logic             if_valid,
    output logic [XLEN-1:0]  if_inst,
    output logic [XLEN-1:0]  if_pc,
    output logic [XLEN-1:0]  if_pc4
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc4;
    logic            kill;
    logic            kill_next;
    logic            capture;
    logic            if_valid_next;
    logic            req_next;
    logic [XLEN-1:0] addr_next;
    logic            redirect;
    logic [XLEN-1:0] target;

    redirect_sel u_redirect_sel (
        .pc_src      (pc_src),
        .jump        (jump),
        .branch_addr (branch_addr),
        .jump_addr   (jump_addr),
        .redirect_c  (redirect),
        .target_c    (target)
    );

    // Next-state, PC, kill and output-buffer decisions.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        kill_next     = kill;
        capture       = 1'b0;
        pc4           = pc + XLEN'(4);

        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem.imem_gnt) begin
                    state_next = WAIT;
                end
                // Request is never retracted; its response is marked wrong-path.
                if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    kill_next = 1'b0;
                    if (kill || redirect) begin
                        state_next = REQ;
                    end else begin
                        capture    = 1'b1;
                        pc_next    = pc4;
                        state_next = stall ? HOLD : REQ;
                    end
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || (if_valid && !stall)) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect) begin
            pc_next = target;
        end

        // Flush beats stall; a fresh capture beats consumption.
        if (redirect) begin
            if_valid_next = 1'b0;
        end else if (capture) begin
            if_valid_next = 1'b1;
        end else if (if_valid && !stall) begin
            if_valid_next = 1'b0;
        end else begin
            if_valid_next = if_valid;
        end

        req_next  = (state_next == REQ);
        addr_next = imem.imem_addr;
        // Address is loaded only when a new request starts, so it stays put until gnt.
        if ((state_next == REQ) && (state != REQ)) begin
            addr_next = align_word(pc_next);
        end
    end

    // Registered state, PC, kill flag, imem request and IF buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
            if_valid       <= 1'b0;
            if_inst        <= '0;
            if_pc          <= '0;
            if_pc4         <= '0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            kill           <= kill_next;
            imem.imem_req  <= req_next;
            imem.imem_addr <= addr_next;
            if_valid       <= if_valid_next;
            if (capture) begin
                if_inst <= imem.imem_rdata;
                if_pc   <= pc;
                if_pc4  <= pc4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed sequences, a redirect vector
// table and randomized traffic against a transaction-level reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [1:0]  jump = 2'b00;
    logic [31:0] jump_addr = '0;
    logic        if_valid;
    logic [31:0] if_inst, if_pc, if_pc4;

    logic        if2_valid;
    logic [31:0] if2_inst, if2_pc, if2_pc4;
    logic        rv2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if mif ();
    fetch_ctrl_if mif2 ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
        .branch_addr(branch_addr), .jump(jump), .jump_addr(jump_addr),
        .imem(mif), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc(if_pc), .if_pc4(if_pc4)
    );

    // Second instance starting at the top of the address space, zero-wait memory.
    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .pc_src(1'b0),
        .branch_addr(32'h0), .jump(2'b00), .jump_addr(32'h0),
        .imem(mif2), .if_valid(if2_valid), .if_inst(if2_inst),
        .if_pc(if2_pc), .if_pc4(if2_pc4)
    );

    assign mif2.imem_gnt    = mif2.imem_req;
    assign mif2.imem_rvalid = rv2;
    assign mif2.imem_rdata  = 32'h0000_0013;
    always @(posedge clk or negedge reset) begin
        if (!reset) rv2 <= 1'b0;
        else        rv2 <= mif2.imem_req;
    end

    // Memory responder state
    bit          mem_pend;
    int          mem_cnt;
    int          req_age;
    int          gnt_lat;
    int          rv_lat;
    bit          rnd_mem;
    logic [31:0] mem_data;

    // Reference model state
    bit          m_idle, m_req, m_wait, m_hold, m_kill, m_v;
    logic [31:0] m_pc, m_addr, m_inst, m_ipc, m_ipc4;

    typedef struct {
        string       name;
        logic        pc_src;
        logic [1:0]  jump;
        logic [31:0] baddr;
        logic [31:0] jaddr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
    } redir_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_hold = 1'b0;
        m_kill = 1'b0; m_v = 1'b0;
        m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    endtask

    // One clock edge of the fetch rules, expressed in terms of pending activities.
    task automatic model_step(input bit g, input bit rv, input logic [31:0] rdata);
        bit          redir, resp, cap, old_v;
        logic [31:0] tgt, n_pc;
        redir = (jump != 2'b00) || pc_src;
        tgt   = ((jump != 2'b00) ? jump_addr : branch_addr) & 32'hFFFF_FFFC;
        resp  = m_wait && rv;
        cap   = resp && !m_kill && !redir;
        n_pc  = redir ? tgt : (cap ? m_pc + 32'd4 : m_pc);
        old_v = m_v;
        if (redir) m_v = 1'b0;
        else if (cap) begin
            m_v = 1'b1; m_inst = rdata; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        end else if (m_v && !stall) m_v = 1'b0;
        if (resp) m_kill = 1'b0;
        else if (redir && (m_req || m_wait)) m_kill = 1'b1;
        if (m_idle) begin
            m_idle = 1'b0; m_req = 1'b1; m_addr = n_pc;
        end else if (m_req) begin
            if (g) begin m_req = 1'b0; m_wait = 1'b1; end
        end else if (m_wait) begin
            if (rv) begin
                m_wait = 1'b0;
                if (cap && stall) m_hold = 1'b1;
                else begin m_req = 1'b1; m_addr = n_pc; end
            end
        end else if (m_hold) begin
            if (redir || (old_v && !stall)) begin
                m_hold = 1'b0; m_req = 1'b1; m_addr = n_pc;
            end
        end
        m_pc = n_pc;
    endtask

    // Drive memory at negedge, advance model at posedge, compare 1 time unit later.
    task automatic cycle();
        bit          g, rv, s_req;
        logic [31:0] rd;
        @(negedge clk);
        s_req = mif.imem_req;
        g  = s_req && !mem_pend && (req_age >= gnt_lat);
        rv = mem_pend && (mem_cnt == 0);
        mif.imem_gnt    = g;
        mif.imem_rvalid = rv;
        mif.imem_rdata  = rv ? mem_data : $urandom;
        @(posedge clk);
        rd = mif.imem_rdata;
        if (rv) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (g) begin
            mem_pend = 1'b1; mem_cnt = rv_lat - 1; mem_data = $urandom; req_age = 0;
            if (rnd_mem) begin
                gnt_lat = $urandom_range(0, 3);
                rv_lat  = $urandom_range(1, 4);
            end
        end else if (s_req) req_age++;
        else req_age = 0;
        if (reset) model_step(g, rv, rd);
        #1;
        chk("model_imem_req", 32'(mif.imem_req), 32'(m_req));
        chk("model_imem_addr", mif.imem_addr, m_addr);
        chk("model_if_valid", 32'(if_valid), 32'(m_v));
        chk("model_if_pc", if_pc, m_ipc);
        chk("model_if_pc4", if_pc4, m_ipc4);
        chk("model_if_inst", if_inst, m_inst);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !if_valid; i++) cycle();
        chk(name, 32'(if_valid), 32'd1);
    endtask

    initial begin
        redir_vec_t  vecs[6];
        logic [31:0] seen[3];
        int          n;
        bit          w_seen_v, w_seen_a, bad, saw_v;

        vecs[0] = '{"branch_only",     1'b1, 2'b00, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0};
        vecs[1] = '{"jal_over_branch", 1'b1, 2'b01, 32'h0000_0040, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0};
        vecs[2] = '{"jalr_align",      1'b0, 2'b10, 32'h0000_0040, 32'h0000_0083, 1'b1, 32'h0000_0080, 1'b0};
        vecs[3] = '{"jump11_as_jalr",  1'b1, 2'b11, 32'h0000_0900, 32'h0000_1237, 1'b1, 32'h0000_1234, 1'b0};
        vecs[4] = '{"branch_align",    1'b1, 2'b00, 32'h0000_0203, 32'h0000_0500, 1'b1, 32'h0000_0200, 1'b0};
        vecs[5] = '{"jal_top",         1'b0, 2'b01, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC, 1'b0};

        mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0; mif.imem_rdata = '0;
        mem_pend = 1'b0; mem_cnt = 0; req_age = 0; gnt_lat = 0; rv_lat = 1; rnd_mem = 1'b0;
        model_reset();

        // Reset values and zero-wait streaming 0,4,8
        cycle();
        chk("rst_imem_req", 32'(mif.imem_req), 32'd0);
        chk("rst_imem_addr", mif.imem_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_wrap_addr", mif2.imem_addr, 32'hFFFF_FFFC);
        reset = 1'b1;
        chk("first_cycle_no_req", 32'(mif.imem_req), 32'd0);
        cycle();
        chk("second_cycle_req", 32'(mif.imem_req), 32'd1);
        n = 0; w_seen_v = 1'b0; w_seen_a = 1'b0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            if (mif.imem_req) begin seen[n] = mif.imem_addr; n++; end
            if (if2_valid && !w_seen_v) begin
                chk("wrap_if_pc", if2_pc, 32'hFFFF_FFFC);
                chk("wrap_if_pc4", if2_pc4, 32'h0);
                w_seen_v = 1'b1;
            end
            if (mif2.imem_req && w_seen_v && !w_seen_a) begin
                chk("wrap_second_addr", mif2.imem_addr, 32'h0);
                w_seen_a = 1'b1;
            end
            cycle();
        end
        chk("stream_count", 32'(n), 32'd3);
        chk("stream_addr0", seen[0], 32'h0);
        chk("stream_addr1", seen[1], 32'h4);
        chk("stream_addr2", seen[2], 32'h8);
        chk("wrap_seen", {30'b0, w_seen_v, w_seen_a}, 32'd3);

        // Stall holds the first instruction in HOLD with no request
        stall = 1'b1;
        do_reset();
        wait_valid("stall_first_capture");
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_no_req", 32'(mif.imem_req), 32'd0);
            chk("hold_if_pc", if_pc, 32'h0);
            chk("hold_if_valid", 32'(if_valid), 32'd1);
        end
        stall = 1'b0;
        cycle();
        chk("unstall_req", 32'(mif.imem_req), 32'd1);
        chk("unstall_addr", mif.imem_addr, 32'h4);

        // Branch while waiting on the response for address 8
        rv_lat = 3;
        do_reset();
        for (int i = 0; i < 40 && !(mif.imem_req && mif.imem_addr == 32'h8); i++) cycle();
        chk("reach_addr8", mif.imem_addr, 32'h8);
        cycle();
        pc_src = 1'b1; branch_addr = 32'h0000_0100;
        cycle();
        pc_src = 1'b0;
        chk("branch_flush", 32'(if_valid), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 20 && !mif.imem_req; i++) begin
            cycle();
            if (if_valid && if_pc == 32'h8) bad = 1'b1;
        end
        chk("branch_target_addr", mif.imem_addr, 32'h100);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (if_valid && if_pc == 32'h8) bad = 1'b1;
        end
        chk("killed_pc8_hidden", 32'(bad), 32'd0);

        // Redirect vector table applied from HOLD
        rv_lat = 1;
        stall = 1'b1;
        do_reset();
        foreach (vecs[k]) begin
            wait_valid({vecs[k].name, "_hold"});
            pc_src = vecs[k].pc_src; jump = vecs[k].jump;
            branch_addr = vecs[k].baddr; jump_addr = vecs[k].jaddr;
            cycle();
            pc_src = 1'b0; jump = 2'b00;
            chk({vecs[k].name, "_req"}, 32'(mif.imem_req), 32'(vecs[k].exp_req));
            chk({vecs[k].name, "_addr"}, mif.imem_addr, vecs[k].exp_addr);
            chk({vecs[k].name, "_valid"}, 32'(if_valid), 32'(vecs[k].exp_valid));
        end
        stall = 1'b0;

        // Late grant with a redirect while the request is pending
        gnt_lat = 3;
        do_reset();
        cycle();
        chk("late_gnt_req", 32'(mif.imem_req), 32'd1);
        jump = 2'b01; jump_addr = 32'h0000_0500;
        cycle();
        jump = 2'b00;
        saw_v = 1'b0;
        for (int i = 0; i < 10 && mif.imem_req; i++) begin
            chk("late_gnt_addr_stable", mif.imem_addr, 32'h0);
            cycle();
        end
        chk("late_gnt_granted", 32'(mif.imem_req), 32'd0);
        for (int i = 0; i < 20 && !mif.imem_req; i++) begin
            cycle();
            if (if_valid) saw_v = 1'b1;
        end
        chk("late_gnt_target", mif.imem_addr, 32'h500);
        chk("late_gnt_dropped", 32'(saw_v), 32'd0);

        // Reset while waiting, then a stale response after reset
        gnt_lat = 0; rv_lat = 6;
        do_reset();
        for (int i = 0; i < 10 && !mif.imem_req; i++) cycle();
        cycle();
        cycle();
        reset = 1'b0;
        model_reset();
        cycle();
        reset = 1'b1;
        saw_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (if_valid) saw_v = 1'b1;
        end
        chk("stale_rvalid_ignored", 32'(saw_v), 32'd0);
        wait_valid("post_reset_capture");
        chk("post_reset_pc", if_pc, 32'h0);

        // Randomized traffic against the model
        rnd_mem = 1'b1; rv_lat = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                pc_src      = 1'($urandom);
                jump        = 2'($urandom);
                branch_addr = $urandom;
                jump_addr   = $urandom;
            end else begin
                pc_src = 1'b0; jump = 2'b00;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
